// File: rtl/btn_dispatcher.sv
// btn_dispatcher
//   Arbitrates pending button flags from the input-handling block and hands
//   one command at a time to the game logic over a valid/ready interface.
//   Each consumed physical press is returned as a one-cycle ack pulse.
//   Held directions auto-repeat. The "any" event is acknowledged
//   immediately and drives the activity pulse. An idle-timeout level flags
//   a long period without presses (attract mode).
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   btn[9:0]      pending buttons {any,roll,peek,hard_new,soft_new,guess,
//                 right,left,down,up}, bit 0 = up
//   ack[9:0]      one-cycle acknowledge pulses, same bit order as btn
//   held_dir[3:0] debounced held state {right,left,down,up}
//   cmd_valid     command offered
//   cmd_ready     game logic accepts the command
//   cmd_code[3:0] 0 up,1 down,2 left,3 right,4 guess,5 soft_new,6 hard_new,
//                 7 peek,8 roll
//   cmd_repeat    command came from auto-repeat only
//   activity      one-cycle pulse per "any" event
//   idle_timeout  no press for IDLE_TIMEOUT cycles
module btn_dispatcher #(
  parameter int unsigned CNT_W         = 30,
  parameter int unsigned REPEAT_DELAY  = 6250000,
  parameter int unsigned REPEAT_PERIOD = 2500000,
  parameter int unsigned IDLE_TIMEOUT  = 750000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  btn,
  output logic [9:0]  ack,
  input  logic [3:0]  held_dir,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_code,
  output logic        cmd_repeat,
  output logic        activity,
  output logic        idle_timeout
);

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (CNT_W < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      64'(REPEAT_DELAY) > CNT_MAX || 64'(REPEAT_PERIOD) > CNT_MAX ||
      64'(IDLE_TIMEOUT) > CNT_MAX) begin : g_bad_params
    $error("btn_dispatcher: parameter does not fit CNT_W or is zero");
  end

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] IDLE_LIM    = CNT_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_ACK} state_t;
  typedef enum logic {PH_DELAY, PH_PERIOD} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [3:0]       rpt_q, rpt_d, rpt_set, rpt_clr;
  logic [3:0]       held_prev_q;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [8:0]       req, rpt9;
  logic [3:0]       win;
  logic [9:0]       ack_d;
  logic             hs, take;

  // Fixed priority: hard_new > soft_new > guess > peek > roll > up > down
  // > left > right.
  function automatic logic [3:0] pick_cmd(input logic [8:0] r);
    logic [3:0] c;
    c = 4'd0;
    if      (r[6]) c = 4'd6;
    else if (r[5]) c = 4'd5;
    else if (r[4]) c = 4'd4;
    else if (r[7]) c = 4'd7;
    else if (r[8]) c = 4'd8;
    else if (r[0]) c = 4'd0;
    else if (r[1]) c = 4'd1;
    else if (r[2]) c = 4'd2;
    else if (r[3]) c = 4'd3;
    return c;
  endfunction

  function automatic logic [1:0] lowest_dir(input logic [3:0] h);
    logic [1:0] d;
    d = 2'd0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (h[i-1]) d = 2'(i - 1);
    end
    return d;
  endfunction

  assign rpt9 = {5'b0, rpt_q};
  assign req  = btn[8:0] | rpt9;
  assign win  = pick_cmd(req);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req)     state_d = S_OFFER;
      S_OFFER: if (cmd_ready) state_d = S_ACK;
      S_ACK:                 state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. cmd_valid decodes the state register so reset drops it
  // asynchronously.
  always_comb begin
    cmd_valid = (state_q == S_OFFER);
    hs        = (state_q == S_OFFER) && cmd_ready;
    take      = (state_q == S_IDLE) && (|req);
  end

  // Ack: "any" is echoed every cycle; a command button is acked only if it
  // is physically pending at the handshake, so a press merged into a
  // repeat is still consumed.
  always_comb begin
    ack_d    = '0;
    ack_d[9] = btn[9];
    if (hs) ack_d[cmd_code] = btn[cmd_code];
  end

  // Auto-repeat timing and flag update. A set in the same cycle as a
  // handshake clear wins.
  always_comb begin
    rpt_set   = '0;
    rpt_clr   = '0;
    phase_d   = phase_q;
    rpt_cnt_d = rpt_cnt_q;
    if (held_dir == '0 || held_dir != held_prev_q) begin
      rpt_cnt_d = '0;
      phase_d   = PH_DELAY;
    end else if (phase_q == PH_DELAY && rpt_cnt_q == DELAY_LAST) begin
      rpt_set[lowest_dir(held_dir)] = 1'b1;
      rpt_cnt_d = '0;
      phase_d   = PH_PERIOD;
    end else if (phase_q == PH_PERIOD && rpt_cnt_q == PERIOD_LAST) begin
      rpt_set[lowest_dir(held_dir)] = 1'b1;
      rpt_cnt_d = '0;
    end else begin
      rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
    end

    if (hs && cmd_code < 4'd4) rpt_clr[cmd_code[1:0]] = 1'b1;
    rpt_d = (held_dir == '0) ? '0 : (rpt_q & ~rpt_clr);
    rpt_d = rpt_d | rpt_set;
  end

  always_comb begin
    if (btn[9])                  idle_cnt_d = '0;
    else if (idle_cnt_q != IDLE_LIM) idle_cnt_d = idle_cnt_q + CNT_W'(1);
    else                         idle_cnt_d = idle_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_code     <= '0;
      cmd_repeat   <= 1'b0;
      ack          <= '0;
      rpt_q        <= '0;
      held_prev_q  <= '0;
      rpt_cnt_q    <= '0;
      phase_q      <= PH_DELAY;
      idle_cnt_q   <= '0;
      idle_timeout <= 1'b0;
    end else begin
      if (take) begin
        cmd_code   <= win;
        cmd_repeat <= rpt9[win] & ~btn[win];
      end
      ack          <= ack_d;
      rpt_q        <= rpt_d;
      held_prev_q  <= held_dir;
      rpt_cnt_q    <= rpt_cnt_d;
      phase_q      <= phase_d;
      idle_cnt_q   <= idle_cnt_d;
      idle_timeout <= (idle_cnt_d == IDLE_LIM);
    end
  end

  assign activity = ack[9];

endmodule

// File: tb/tb_btn_dispatcher.sv
module tb_btn_dispatcher;

  logic       clk;
  logic       rst_n;
  logic [9:0] btn;
  logic [9:0] ack;
  logic [3:0] held_dir;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_code;
  logic       cmd_repeat;
  logic       activity;
  logic       idle_timeout;

  int n_cmp;
  int n_err;

  btn_dispatcher #(
    .CNT_W         (30),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4),
    .IDLE_TIMEOUT  (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .ack          (ack),
    .held_dir     (held_dir),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .cmd_repeat   (cmd_repeat),
    .activity     (activity),
    .idle_timeout (idle_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    btn = '0;
    held_dir = '0;
    cmd_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_code", 32'(cmd_code), 32'd0);
    check("rst_repeat", 32'(cmd_repeat), 32'd0);
    check("rst_activity", 32'(activity), 32'd0);
    check("rst_idle", 32'(idle_timeout), 32'd0);
    rst_n = 1'b1;

    // Idle timeout: rises after exactly 20 press-free edges
    repeat (19) tick();
    check("idle_19", 32'(idle_timeout), 32'd0);
    tick();
    check("idle_20", 32'(idle_timeout), 32'd1);
    btn[9] = 1'b1;
    tick();
    check("any_ack", 32'(ack), 32'h200);
    check("any_activity", 32'(activity), 32'd1);
    check("any_idle_drop", 32'(idle_timeout), 32'd0);
    check("any_no_cmd", 32'(cmd_valid), 32'd0);
    btn[9] = 1'b0;
    tick();
    check("any_ack_end", 32'(ack), 32'd0);
    check("any_activity_end", 32'(activity), 32'd0);
    check("any_idle_low", 32'(idle_timeout), 32'd0);

    // Priority: up, guess, hard_new pending together
    btn = 10'h051;
    cmd_ready = 1'b1;
    check("prio_c0_valid", 32'(cmd_valid), 32'd0);
    tick();
    check("prio_c1_valid", 32'(cmd_valid), 32'd1);
    check("prio_c1_code", 32'(cmd_code), 32'd6);
    check("prio_c1_repeat", 32'(cmd_repeat), 32'd0);
    check("prio_c1_ack", 32'(ack), 32'd0);
    tick();
    check("prio_c2_valid", 32'(cmd_valid), 32'd0);
    check("prio_c2_ack", 32'(ack), 32'h040);
    btn[6] = 1'b0;
    tick();
    check("prio_c3_ack", 32'(ack), 32'd0);
    check("prio_c3_valid", 32'(cmd_valid), 32'd0);
    tick();
    check("prio_c4_valid", 32'(cmd_valid), 32'd1);
    check("prio_c4_code", 32'(cmd_code), 32'd4);
    tick();
    check("prio_c5_ack", 32'(ack), 32'h010);
    btn[4] = 1'b0;
    tick();
    check("prio_c6_ack", 32'(ack), 32'd0);
    check("prio_c6_valid", 32'(cmd_valid), 32'd0);
    tick();
    check("prio_c7_valid", 32'(cmd_valid), 32'd1);
    check("prio_c7_code", 32'(cmd_code), 32'd0);
    check("prio_c7_repeat", 32'(cmd_repeat), 32'd0);
    tick();
    check("prio_c8_ack", 32'(ack), 32'h001);
    btn[0] = 1'b0;
    tick();
    check("prio_c9_ack", 32'(ack), 32'd0);
    tick();
    check("prio_c10_valid", 32'(cmd_valid), 32'd0);

    // Backpressure: guess offered while ready low for 5 cycles
    cmd_ready = 1'b0;
    btn = 10'h010;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("bp_valid", 32'(cmd_valid), 32'd1);
      check("bp_code", 32'(cmd_code), 32'd4);
      check("bp_ack", 32'(ack), 32'd0);
    end
    cmd_ready = 1'b1;
    tick();
    check("bp_ack_pulse", 32'(ack), 32'h010);
    check("bp_valid_drop", 32'(cmd_valid), 32'd0);
    btn = '0;
    tick();
    check("bp_ack_end", 32'(ack), 32'd0);
    check("bp_idle_valid", 32'(cmd_valid), 32'd0);

    // Auto-repeat: left held for 30 cycles, ready high
    held_dir = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      check("rpt_valid", 32'(cmd_valid), 32'((i >= 10) && ((i - 10) % 4 == 0)));
      if (i >= 10 && (i - 10) % 4 == 0) begin
        check("rpt_code", 32'(cmd_code), 32'd2);
        check("rpt_flag", 32'(cmd_repeat), 32'd1);
      end
      check("rpt_ack", 32'(ack), 32'd0);
      tick();
    end
    held_dir = '0;
    check("rpt_c30_valid", 32'(cmd_valid), 32'd1);
    check("rpt_c30_code", 32'(cmd_code), 32'd2);
    tick();
    check("rpt_c31_valid", 32'(cmd_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rpt_after_release", 32'(cmd_valid), 32'd0);
      check("rpt_after_ack", 32'(ack), 32'd0);
    end

    // Merge: up repeat pending, then up pressed before it is latched
    cmd_ready = 1'b0;
    btn = 10'h010;
    held_dir = 4'b0001;
    tick();
    check("mrg_c1_valid", 32'(cmd_valid), 32'd1);
    check("mrg_c1_code", 32'(cmd_code), 32'd4);
    repeat (8) tick();
    btn[0] = 1'b1;
    tick();
    check("mrg_c10_code", 32'(cmd_code), 32'd4);
    cmd_ready = 1'b1;
    tick();
    check("mrg_c11_ack", 32'(ack), 32'h010);
    btn[4] = 1'b0;
    tick();
    check("mrg_c12_valid", 32'(cmd_valid), 32'd0);
    tick();
    check("mrg_c13_valid", 32'(cmd_valid), 32'd1);
    check("mrg_c13_code", 32'(cmd_code), 32'd0);
    check("mrg_c13_repeat", 32'(cmd_repeat), 32'd0);
    tick();
    check("mrg_c14_ack", 32'(ack), 32'h001);
    btn = '0;
    held_dir = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrg_no_second", 32'(cmd_valid), 32'd0);
      check("mrg_ack_quiet", 32'(ack), 32'd0);
    end

    // Release clears a repeat that is pending behind a busy offer
    cmd_ready = 1'b0;
    btn = 10'h010;
    held_dir = 4'b0010;
    tick();
    check("rel_c1_code", 32'(cmd_code), 32'd4);
    repeat (9) tick();
    held_dir = '0;
    tick();
    check("rel_c11_valid", 32'(cmd_valid), 32'd1);
    check("rel_c11_code", 32'(cmd_code), 32'd4);
    cmd_ready = 1'b1;
    tick();
    check("rel_c12_ack", 32'(ack), 32'h010);
    btn = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rel_no_repeat", 32'(cmd_valid), 32'd0);
    end

    // Reset during an offer
    check("rr_idle_before", 32'(idle_timeout), 32'd1);
    cmd_ready = 1'b0;
    btn = 10'h001;
    tick();
    check("rr_offer_valid", 32'(cmd_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rr_valid_async", 32'(cmd_valid), 32'd0);
    check("rr_ack_async", 32'(ack), 32'd0);
    check("rr_idle_async", 32'(idle_timeout), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rr_after_release", 32'(cmd_valid), 32'd0);
    tick();
    check("rr_reoffer_valid", 32'(cmd_valid), 32'd1);
    check("rr_reoffer_code", 32'(cmd_code), 32'd0);
    check("rr_reoffer_repeat", 32'(cmd_repeat), 32'd0);
    cmd_ready = 1'b1;
    tick();
    check("rr_ack", 32'(ack), 32'h001);
    btn = '0;
    tick();
    check("rr_ack_end", 32'(ack), 32'd0);
    check("rr_valid_end", 32'(cmd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
